// File: rtl/mul_rr_scheduler_if.sv
// Request-side and shared-multiplier signals of mul_rr_scheduler, bundled for port reuse.
// master: requesters plus multiplier; slave: the scheduler itself.
interface mul_rr_scheduler_if;
    logic [3:0]  req;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        busy;
    logic        mul_en;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  mul_p;

    modport master (
        output req, req_x, req_y, mul_p,
        input  gnt, done, result, busy, mul_en, mul_x, mul_y
    );

    modport slave (
        input  req, req_x, req_y, mul_p,
        output gnt, done, result, busy, mul_en, mul_x, mul_y
    );
endinterface

// File: rtl/mul_rr_scheduler.sv
// Round-robin arbiter sharing one 4x4 multiplier among 4 requesters; optional MUL_SCHED_ZERO_SKIP_EN.
// Latency: MUL_LAT+3 cycles per operation (IDLE, ISSUE, MUL_LAT x WAIT, CAPTURE); 2 with a zero skip.
// Backpressure: level requests are held off until the scheduler returns to IDLE; no abort once granted.
module mul_rr_scheduler #(
    parameter int MUL_LAT = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_rr_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      gnt_q;
    logic [3:0]      done_q;
    logic [7:0]      result_q;
    logic            busy_q;
    logic            mul_en_q;
    logic [3:0]      mul_x_q;
    logic [3:0]      mul_y_q;
`ifdef MUL_SCHED_ZERO_SKIP_EN
    logic            skip_q;
`endif

    logic [1:0]      win_d;
    logic [3:0]      x_d;
    logic [3:0]      y_d;

    // Scan from the highest offset down so the closest requester to ptr_q wins.
    always_comb begin
        win_d = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                win_d = ptr_q + 2'(k);
            end
        end
        x_d = bus.req_x[{win_d, 2'b00} +: 4];
        y_d = bus.req_y[{win_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            mul_en_q <= 1'b0;
            mul_x_q  <= '0;
            mul_y_q  <= '0;
`ifdef MUL_SCHED_ZERO_SKIP_EN
            skip_q   <= 1'b0;
`endif
        end else begin
            done_q   <= '0;
            mul_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        ptr_q   <= win_d + 2'd1;
                        gnt_q   <= 4'b0001 << win_d;
                        mul_x_q <= x_d;
                        mul_y_q <= y_d;
                        busy_q  <= 1'b1;
`ifdef MUL_SCHED_ZERO_SKIP_EN
                        if (x_d == 4'd0 || y_d == 4'd0) begin
                            skip_q  <= 1'b1;
                            state_q <= CAPTURE;
                        end else begin
                            skip_q   <= 1'b0;
                            mul_en_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
`else
                        mul_en_q <= 1'b1;
                        state_q  <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CAPTURE: begin
`ifdef MUL_SCHED_ZERO_SKIP_EN
                    result_q <= skip_q ? 8'd0 : bus.mul_p;
`else
                    result_q <= bus.mul_p;
`endif
                    done_q  <= gnt_q;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.mul_en = mul_en_q;
    assign bus.mul_x  = mul_x_q;
    assign bus.mul_y  = mul_y_q;
endmodule
